// File: rtl/mu0_pkg.sv
// mu0_pkg: shared MU0 sequencer state encoding and opcode constants.
package mu0_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] STP_OPCODE = OP_STP;
endpackage

// File: rtl/mu0_sequencer_if.sv
// mu0_sequencer_if: sequencer control/strobe bundle; CYCLES/INSTRS exist only with MU0_SEQ_PERF_COUNTERS_EN.
interface mu0_sequencer_if #(parameter int CNT_W = 32);
  logic RUN, STEP, MEM_READY, EXTRA, SKIP_REQ;
  logic [3:0] IR_OP;
  logic FETCH, EXEC1, EXEC2, IR_EN, skipstatus, HALTED;
`ifdef MU0_SEQ_PERF_COUNTERS_EN
  logic [CNT_W-1:0] CYCLES, INSTRS;
  modport master (output RUN, STEP, MEM_READY, EXTRA, SKIP_REQ, IR_OP,
                  input FETCH, EXEC1, EXEC2, IR_EN, skipstatus, HALTED, CYCLES, INSTRS);
  modport slave (input RUN, STEP, MEM_READY, EXTRA, SKIP_REQ, IR_OP,
                 output FETCH, EXEC1, EXEC2, IR_EN, skipstatus, HALTED, CYCLES, INSTRS);
`else
  modport master (output RUN, STEP, MEM_READY, EXTRA, SKIP_REQ, IR_OP,
                  input FETCH, EXEC1, EXEC2, IR_EN, skipstatus, HALTED);
  modport slave (input RUN, STEP, MEM_READY, EXTRA, SKIP_REQ, IR_OP,
                 output FETCH, EXEC1, EXEC2, IR_EN, skipstatus, HALTED);
`endif
endinterface

// File: rtl/mu0_perf_counter.sv
// mu0_perf_counter: enabled counter wrapping modulo 2^W, cleared only by reset.
module mu0_perf_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 FETCH/EXEC1/EXEC2 phase sequencer with skip, run/step/halt; MU0_SEQ_PERF_COUNTERS_EN adds CYCLES/INSTRS.
module mu0_sequencer #(
  parameter logic [3:0] STP_OPCODE = mu0_pkg::STP_OPCODE,
  parameter int         CNT_W      = 32
) (
  input logic            CLK,
  input logic            RESET_N,
  mu0_sequencer_if.slave bus
);
  import mu0_pkg::*;
  state_t state_q, state_d;
  logic step_q, step_d, skip_q, skip_d;
  logic fetch_q, fetch_d, exec1_q, exec1_d, exec2_q, exec2_d, halted_q, halted_d;
  logic stp, retire;
  always_comb begin
    stp = state_q == S_EXEC1 && bus.IR_OP == STP_OPCODE && !skip_q;
    retire = (state_q == S_EXEC1 && !stp && !bus.EXTRA) || (state_q == S_EXEC2 && bus.MEM_READY);
    state_d = state_q;
    step_d = step_q;
    case (state_q)
      S_IDLE: begin
        state_d = (bus.RUN || bus.STEP) ? S_FETCH : S_IDLE;
        step_d = !bus.RUN && bus.STEP;
      end
      S_FETCH: state_d = bus.MEM_READY ? S_EXEC1 : S_FETCH;
      S_EXEC1: state_d = stp ? S_HALT : bus.EXTRA ? S_EXEC2 : S_EXEC1;
      default: state_d = state_q;
    endcase
    // a pending step forces the boundary back to IDLE even if RUN rose meanwhile
    if (retire) begin
      state_d = (bus.RUN && !step_q) ? S_FETCH : S_IDLE;
      step_d = 1'b0;
    end
    skip_d = retire ? (!skip_q && bus.SKIP_REQ) : skip_q;
    fetch_d = state_d == S_FETCH;
    exec1_d = state_d == S_EXEC1;
    exec2_d = state_d == S_EXEC2;
    halted_d = state_d == S_IDLE || state_d == S_HALT;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= S_IDLE;
      step_q <= 1'b0;
      skip_q <= 1'b0;
      fetch_q <= 1'b0;
      exec1_q <= 1'b0;
      exec2_q <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      skip_q <= skip_d;
      fetch_q <= fetch_d;
      exec1_q <= exec1_d;
      exec2_q <= exec2_d;
      halted_q <= halted_d;
    end
  assign bus.FETCH = fetch_q;
  assign bus.EXEC1 = exec1_q;
  assign bus.EXEC2 = exec2_q;
  assign bus.IR_EN = fetch_q & bus.MEM_READY;
  assign bus.skipstatus = skip_q;
  assign bus.HALTED = halted_q;
`ifdef MU0_SEQ_PERF_COUNTERS_EN
  mu0_perf_counter #(.W(CNT_W)) u_cycles (.clk(CLK), .rst_n(RESET_N), .en(!halted_q), .cnt(bus.CYCLES));
  mu0_perf_counter #(.W(CNT_W)) u_instrs (.clk(CLK), .rst_n(RESET_N), .en(retire), .cnt(bus.INSTRS));
`endif
endmodule

// File: doc/mu0_sequencer.md
Name: mu0_sequencer

Overview:
- Control-state sequencer for the MU0/ARMish CPU. It generates the one-hot FETCH/EXEC1/EXEC2 phase strobes consumed by the instruction decoder.
- Owns the skip-status flag, run/halt/single-step control and memory wait handshaking.
- Sits between the decoder (takes EXTRA and IR[15:12]) and the top-level CPU/debug controls.

Parameters:
- STP_OPCODE, 4'b0111, IR[15:12] value that halts the CPU.
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- RUN  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
- STEP  in  1  one-cycle pulse; executes exactly one instruction while stopped.
- MEM_READY  in  1  memory access complete this cycle.
- EXTRA  in  1  from decoder; current instruction needs EXEC2.
- IR_OP  in  4  IR[15:12] of the latched instruction.
- SKIP_REQ  in  1  datapath skip condition, sampled in the final exec cycle.
- FETCH  out  1  fetch phase strobe.
- EXEC1  out  1  first execute phase.
- EXEC2  out  1  second execute phase.
- IR_EN  out  1  load IR; equals FETCH & MEM_READY.
- skipstatus  out  1  suppress side effects of the current instruction.
- HALTED  out  1  in the HALT or IDLE state.
- CYCLES  out  CNT_W  cycle count; present only with the feature macro.
- INSTRS  out  CNT_W  retired-instruction count; present only with the feature macro.

Behaviour:
- State encoding: IDLE, FETCH, EXEC1, EXEC2, HALT. FETCH/EXEC1/EXEC2 are registered one-hot decodes of the state; at most one is high in any cycle.
- Reset (async, RESET_N=0): state=IDLE, skipstatus=0, all strobes 0, IR_EN=0, HALTED=1, counters=0.
- IDLE:
  - RUN=1 -> FETCH.
  - STEP=1 -> FETCH and set the internal step_pending flag.
  - Otherwise stay.
- FETCH:
  - Wait while MEM_READY=0.
  - On MEM_READY=1: IR_EN=1 in the same cycle, next state EXEC1.
- EXEC1:
  - If IR_OP==STP_OPCODE and skipstatus=0 -> HALT (instruction not retired).
  - Else if EXTRA=1 -> EXEC2, with no wait in EXEC1.
  - Else the instruction retires and goes to the boundary.
- EXEC2: wait while MEM_READY=0; when MEM_READY=1 the instruction retires and goes to the boundary.
- Boundary, taken on retire:
  - RUN=1 and step_pending=0 -> FETCH.
  - Otherwise -> IDLE and clear step_pending.
- HALT:
  - Sticky; only reset leaves it.
  - RUN and STEP are ignored.
  - HALTED=1.
- skipstatus:
  - On retire with SKIP_REQ=1 and skipstatus=0: set to 1 for the whole of the next instruction (FETCH through its retire).
  - On retire with skipstatus=1: cleared. SKIP_REQ is ignored, so there is no chained skip.
  - A skipped STP does not halt; it retires normally.
  - A skipped instruction still spends its EXEC2 cycle when EXTRA=1, so PC advance timing is unchanged.
- Simultaneous events:
  - RUN falling mid-instruction: the current instruction completes; the stop takes effect at the boundary.
  - STEP while RUN=1 or in a non-IDLE state: ignored.
  - STEP and RUN both high in IDLE: RUN wins, no step_pending.
- Reset mid-instruction: immediate return to IDLE. The skip flag is lost.
- Latency:
  - Non-EXTRA instruction: 2 cycles minimum (FETCH, EXEC1).
  - EXTRA instruction: 3 cycles minimum. Each MEM_READY=0 cycle adds one.

Optional Feature:
- Macro: MU0_SEQ_PERF_COUNTERS_EN.
- Defined:
  - CYCLES increments in every non-IDLE, non-HALT cycle.
  - INSTRS increments on each retire, including skipped instructions; STP itself is excluded.
  - Both wrap modulo 2^CNT_W and are cleared only by reset.
- Undefined: the CYCLES/INSTRS ports and their logic are absent.

Decomposition:
- Shared package mu0_pkg holds:
  - the state enum (IDLE/FETCH/EXEC1/EXEC2/HALT);
  - the opcode constants LDA..ASR and STP_OPCODE, which the decoder also uses.
- Optional sub-module mu0_perf_counter: an enabled wrapping counter, instantiated twice.

Test Plan:
- Reset then RUN=1, MEM_READY=1, EXTRA=0, IR_OP=4'b1000 (LDI) -> strobes FETCH,EXEC1,FETCH,EXEC1... with a 2-cycle period; HALTED drops the cycle after RUN is seen.
- EXTRA=1 (LDA, IR_OP=0000), MEM_READY low for 2 cycles in EXEC2 -> EXEC2 held 3 cycles, then FETCH; IR_EN pulses once per fetch.
- SKIP_REQ=1 on retire of instruction A -> skipstatus=1 from the next FETCH through B's retire, then 0.
- Instruction B is STP (0111) while skipstatus=1 -> no halt, returns to FETCH.
- Unskipped STP -> HALT, HALTED=1 and held. A later RUN toggle or STEP does nothing; RESET_N low returns to IDLE.
- RUN=0, STEP pulse in IDLE -> exactly one instruction is executed, then IDLE.
- STEP during EXEC1 -> ignored.
- With MU0_SEQ_PERF_COUNTERS_EN and CNT_W=4: 20 retired 2-cycle instructions -> INSTRS=20 mod 16=4, CYCLES=40 mod 16=8.
